// File: rtl/spu_sched_pkg.sv
// Shared constants and issue-slot payload for the SPU issue-stage scoreboard.
package spu_sched_pkg;

    localparam int unsigned NUM_REGS = 128;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned LAT_W    = 3;
    localparam int unsigned BUSY_W   = 8;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [2:0]        src_use;
        logic              wr;
        logic [ADDR_W-1:0] rt;
        logic [LAT_W-1:0]  lat;
    } issue_slot_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Per-slot scoreboard lookup: RAW hits on used sources and WAW against the pending write.
module sb_hazard_check
    import spu_sched_pkg::*;
(
    input  issue_slot_t      slot,
    input  logic [LAT_W-1:0] cnt [NUM_REGS],
    output logic [2:0]       raw,
    output logic             waw
);

    // A count of 1 lands this cycle and is forwarded, so only >= 2 stalls a reader.
    always_comb begin
        raw = 3'b000;
        waw = 1'b0;
        if (slot.en) begin
            raw[2] = slot.src_use[2] && (cnt[slot.ra] >= LAT_W'(2));
            raw[1] = slot.src_use[1] && (cnt[slot.rb] >= LAT_W'(2));
            raw[0] = slot.src_use[0] && (cnt[slot.rc] >= LAT_W'(2));
            waw    = slot.wr && (cnt[slot.rt] >= slot.lat);
        end
    end

endmodule

// File: rtl/dual_issue_scoreboard.sv
// Dual-issue scoreboard: per-register writeback countdowns, in-order pair grants with split on intra-pair dependence.
module dual_issue_scoreboard
    import spu_sched_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              flush,
    input  logic              even_en,
    input  logic              odd_en,
    input  logic [ADDR_W-1:0] even_ra,
    input  logic [ADDR_W-1:0] even_rb,
    input  logic [ADDR_W-1:0] even_rc,
    input  logic [2:0]        even_src_use,
    input  logic [ADDR_W-1:0] odd_ra,
    input  logic [ADDR_W-1:0] odd_rb,
    input  logic [ADDR_W-1:0] odd_rs,
    input  logic [2:0]        odd_src_use,
    input  logic              even_wr,
    input  logic              odd_wr,
    input  logic [ADDR_W-1:0] even_rt,
    input  logic [ADDR_W-1:0] odd_rt,
    input  logic [LAT_W-1:0]  even_lat,
    input  logic [LAT_W-1:0]  odd_lat,
    output logic              accept_even,
    output logic              accept_odd,
    output logic [5:0]        hazard_mask,
    output logic [BUSY_W-1:0] busy_count
);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];

    issue_slot_t even_slot;
    issue_slot_t odd_slot;
    logic [2:0]  even_raw;
    logic [2:0]  odd_raw;
    logic        even_waw;
    logic        odd_waw;
    logic        grant_ok;
    logic        odd_src_hit;
    logic        intra_conflict;

    assign even_slot = '{en: even_en, ra: even_ra, rb: even_rb, rc: even_rc,
                         src_use: even_src_use, wr: even_wr, rt: even_rt, lat: even_lat};
    assign odd_slot  = '{en: odd_en, ra: odd_ra, rb: odd_rb, rc: odd_rs,
                         src_use: odd_src_use, wr: odd_wr, rt: odd_rt, lat: odd_lat};

    sb_hazard_check u_even_chk (
        .slot (even_slot),
        .cnt  (cnt_q),
        .raw  (even_raw),
        .waw  (even_waw)
    );

    sb_hazard_check u_odd_chk (
        .slot (odd_slot),
        .cnt  (cnt_q),
        .raw  (odd_raw),
        .waw  (odd_waw)
    );

    // Program-order grants; odd is split off when it depends on an accepted even writer.
    always_comb begin
        grant_ok    = issue_valid && !flush && !reset;
        accept_even = grant_ok && even_en && (even_raw == 3'b000) && !even_waw;
        odd_src_hit = (odd_src_use[2] && (odd_ra == even_rt)) ||
                      (odd_src_use[1] && (odd_rb == even_rt)) ||
                      (odd_src_use[0] && (odd_rs == even_rt));
        intra_conflict = accept_even && even_wr &&
                         (odd_src_hit || (odd_wr && (odd_rt == even_rt) && (odd_lat <= even_lat)));
        accept_odd  = grant_ok && odd_en && (odd_raw == 3'b000) && !odd_waw && !intra_conflict &&
                      (accept_even || !even_en);
        hazard_mask = reset ? 6'b000000 : {even_raw, odd_raw};
    end

    // Decrement everything, then apply loads; odd is applied last so it wins on a shared rt.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        if (accept_even && even_wr) begin
            cnt_d[even_rt] = even_lat;
        end
        if (accept_odd && odd_wr) begin
            cnt_d[odd_rt] = odd_lat;
        end
        if (flush) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_comb begin
        busy_count = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_count = busy_count + BUSY_W'(cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// Directed self-checking bench for dual_issue_scoreboard with hand-computed expectations.
module tb_dual_issue_scoreboard;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic       flush;
    logic       even_en, odd_en;
    logic [6:0] even_ra, even_rb, even_rc;
    logic [2:0] even_src_use;
    logic [6:0] odd_ra, odd_rb, odd_rs;
    logic [2:0] odd_src_use;
    logic       even_wr, odd_wr;
    logic [6:0] even_rt, odd_rt;
    logic [2:0] even_lat, odd_lat;
    logic       accept_even, accept_odd;
    logic [5:0] hazard_mask;
    logic [7:0] busy_count;

    int n_vec = 0;
    int n_err = 0;

    dual_issue_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .flush        (flush),
        .even_en      (even_en),
        .odd_en       (odd_en),
        .even_ra      (even_ra),
        .even_rb      (even_rb),
        .even_rc      (even_rc),
        .even_src_use (even_src_use),
        .odd_ra       (odd_ra),
        .odd_rb       (odd_rb),
        .odd_rs       (odd_rs),
        .odd_src_use  (odd_src_use),
        .even_wr      (even_wr),
        .odd_wr       (odd_wr),
        .even_rt      (even_rt),
        .odd_rt       (odd_rt),
        .even_lat     (even_lat),
        .odd_lat      (odd_lat),
        .accept_even  (accept_even),
        .accept_odd   (accept_odd),
        .hazard_mask  (hazard_mask),
        .busy_count   (busy_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && issue_valid &&
            ((even_en && even_wr && even_lat == 3'd0) || (odd_en && odd_wr && odd_lat == 3'd0)))
            $error("illegal zero latency presented");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_even(input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc,
                            input logic [2:0] u, input logic wr, input logic [6:0] rt,
                            input logic [2:0] lat);
        even_en = 1'b1; even_ra = ra; even_rb = rb; even_rc = rc;
        even_src_use = u; even_wr = wr; even_rt = rt; even_lat = lat;
    endtask

    task automatic set_odd(input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rs,
                           input logic [2:0] u, input logic wr, input logic [6:0] rt,
                           input logic [2:0] lat);
        odd_en = 1'b1; odd_ra = ra; odd_rb = rb; odd_rs = rs;
        odd_src_use = u; odd_wr = wr; odd_rt = rt; odd_lat = lat;
    endtask

    task automatic clr_even();
        even_en = 1'b0; even_ra = '0; even_rb = '0; even_rc = '0;
        even_src_use = '0; even_wr = 1'b0; even_rt = '0; even_lat = 3'd1;
    endtask

    task automatic clr_odd();
        odd_en = 1'b0; odd_ra = '0; odd_rb = '0; odd_rs = '0;
        odd_src_use = '0; odd_wr = 1'b0; odd_rt = '0; odd_lat = 3'd1;
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        flush       = 1'b0;
        clr_even();
        clr_odd();
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        clr_even();
        clr_odd();
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd5, 3'd4);
        #2;
        check("rst_acc_e", 32'(accept_even), 32'd0);
        check("rst_busy", 32'(busy_count), 32'd0);
        check("rst_haz", 32'(hazard_mask), 32'd0);
        #10;
        reset = 1'b0;

        // Stalled dependency on r5 (lat 4)
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd5, 3'd4);
        #1;
        check("t1_issue", 32'(accept_even), 32'd1);
        tick();
        set_even(7'd5, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        #1;
        check("t1_busy", 32'(busy_count), 32'd1);
        for (int c = 1; c <= 3; c++) begin
            check("t1_stall_acc", 32'(accept_even), 32'd0);
            check("t1_stall_haz", 32'(hazard_mask), 32'h20);
            tick();
            #1;
        end
        check("t1_go_acc", 32'(accept_even), 32'd1);
        check("t1_go_haz", 32'(hazard_mask), 32'd0);
        idle(8);
        #1;
        check("t1_drained", 32'(busy_count), 32'd0);

        // Intra-pair split on r10
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd10, 3'd2);
        set_odd(7'd10, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        #1;
        check("t2_acc_e", 32'(accept_even), 32'd1);
        check("t2_acc_o", 32'(accept_odd), 32'd0);
        check("t2_haz", 32'(hazard_mask), 32'd0);
        tick();
        clr_even();
        #1;
        check("t2_odd_stall", 32'(accept_odd), 32'd0);
        check("t2_odd_haz", 32'(hazard_mask), 32'h04);
        tick();
        #1;
        check("t2_odd_go", 32'(accept_odd), 32'd1);
        idle(8);

        // Independent pair issues together
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd11, 3'd3);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd12, 3'd5);
        #1;
        check("t2b_acc_e", 32'(accept_even), 32'd1);
        check("t2b_acc_o", 32'(accept_odd), 32'd1);
        tick();
        issue_valid = 1'b0; clr_even(); clr_odd();
        #1;
        check("t2b_busy", 32'(busy_count), 32'd2);
        idle(8);

        // Same rt in a pair: odd (lat 4) load wins over even (lat 2)
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd13, 3'd2);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd13, 3'd4);
        #1;
        check("t2c_acc_e", 32'(accept_even), 32'd1);
        check("t2c_acc_o", 32'(accept_odd), 32'd1);
        tick();
        clr_odd();
        set_even(7'd13, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        #1;
        for (int c = 0; c < 3; c++) begin
            check("t2c_stall", 32'(accept_even), 32'd0);
            tick();
            #1;
        end
        check("t2c_go", 32'(accept_even), 32'd1);
        idle(8);

        // Intra-pair WAW: odd needs strictly greater latency
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd14, 3'd3);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd14, 3'd3);
        #1;
        check("t2d_acc_e", 32'(accept_even), 32'd1);
        check("t2d_eq_lat", 32'(accept_odd), 32'd0);
        odd_lat = 3'd4;
        #1;
        check("t2d_gt_lat", 32'(accept_odd), 32'd1);
        idle(8);

        // Blocked even holds back an independent odd
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd15, 3'd7);
        tick();
        set_even(7'd15, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd16, 3'd1);
        #1;
        check("t2e_acc_e", 32'(accept_even), 32'd0);
        check("t2e_acc_o", 32'(accept_odd), 32'd0);
        clr_even();
        #1;
        check("t2e_odd_alone", 32'(accept_odd), 32'd1);
        idle(8);

        // WAW on r20: cnt 6, new write lat 2
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd20, 3'd6);
        #1;
        check("t3_first", 32'(accept_even), 32'd1);
        tick();
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd20, 3'd2);
        #1;
        for (int c = 0; c < 5; c++) begin
            check("t3_waw_stall", 32'(accept_even), 32'd0);
            check("t3_waw_haz", 32'(hazard_mask), 32'd0);
            tick();
            #1;
        end
        check("t3_waw_go", 32'(accept_even), 32'd1);
        tick();
        set_even(7'd20, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        #1;
        check("t3_reload_stall", 32'(accept_even), 32'd0);
        check("t3_reload_haz", 32'(hazard_mask), 32'h20);
        tick();
        #1;
        check("t3_reload_go", 32'(accept_even), 32'd1);
        idle(8);

        // Unused source on busy r7 (cnt 5)
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd7, 3'd5);
        tick();
        set_even(7'd7, 7'd0, 7'd0, 3'b000, 1'b0, 7'd0, 3'd1);
        #1;
        check("t4_unused_acc", 32'(accept_even), 32'd1);
        check("t4_unused_haz", 32'(hazard_mask), 32'd0);
        even_rb = 7'd7;
        even_src_use = 3'b010;
        #1;
        check("t4_rb_acc", 32'(accept_even), 32'd0);
        check("t4_rb_haz", 32'(hazard_mask), 32'h10);
        idle(8);

        // Flush with three busy registers
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd30, 3'd7);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd31, 3'd7);
        tick();
        clr_odd();
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd32, 3'd7);
        tick();
        set_even(7'd1, 7'd2, 7'd3, 3'b111, 1'b1, 7'd33, 3'd3);
        set_odd(7'd4, 7'd5, 7'd6, 3'b111, 1'b1, 7'd34, 3'd3);
        flush = 1'b1;
        #1;
        check("t5_busy_pre", 32'(busy_count), 32'd3);
        check("t5_flush_acc_e", 32'(accept_even), 32'd0);
        check("t5_flush_acc_o", 32'(accept_odd), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("t5_busy_post", 32'(busy_count), 32'd0);
        check("t5_after_acc_e", 32'(accept_even), 32'd1);
        check("t5_after_acc_o", 32'(accept_odd), 32'd1);
        idle(8);

        // Asynchronous reset between edges
        issue_valid = 1'b1;
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd1, 3'd7);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd2, 3'd7);
        tick();
        clr_odd();
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 1'b1, 7'd3, 3'd2);
        #1;
        check("t6_busy_pre", 32'(busy_count), 32'd2);
        reset = 1'b1;
        #1;
        check("t6_busy_rst", 32'(busy_count), 32'd0);
        check("t6_acc_in_rst", 32'(accept_even), 32'd0);
        reset = 1'b0;
        set_even(7'd1, 7'd0, 7'd0, 3'b100, 1'b0, 7'd0, 3'd1);
        #1;
        check("t6_reader_acc", 32'(accept_even), 32'd1);
        check("t6_reader_haz", 32'(hazard_mask), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
